// File: rtl/div_mode_ctrl.sv
// div_mode_ctrl -- reconfiguration sequencer for the FMDLL clock divider.
//
// Owns the divider's M select and active-low reset, and gates downstream use
// of the divided clocks. A mode change runs GATE -> HOLD -> LOCK -> RUN:
// clk_en drops, the divider is held in reset with the new M applied, the
// divider is released, and lock is verified by counting synchronized
// div_clk4 rising edges before clk_en is re-asserted. A lock timeout parks
// the block in ERR with the divider held in reset.
//
// Optional build macro: DIV_MODE_CTRL_AUTO_RETRY_EN
//   defined   : the first LOCK timeout of a sequence re-runs HOLD/LOCK with the
//               same M; a second timeout goes to ERR.
//   undefined : the first LOCK timeout goes straight to ERR.
//
// Ports:
//   clk_ext   in   reference clock, all logic on its rising edge
//   rst       in   asynchronous active-high reset
//   cfg_req   in   4-phase mode-change request
//   cfg_m     in   requested M (2 bits), sampled on acceptance
//   cfg_ack   out  request accepted, held until cfg_req falls
//   cfg_nak   out  one-cycle pulse when a request with cfg_m == 0 is rejected
//   div_clk4  in   divider clk4 output, asynchronous to clk_ext
//   div_m     out  divider M select (2 bits)
//   div_rst_n out  divider reset, active low
//   clk_en    out  divided clocks valid for downstream use
//   busy      out  a sequence is in progress
//   locked    out  divider verified running at div_m
//   err       out  lock timeout, sticky until the next accepted request
module div_mode_ctrl #(
  parameter logic [1:0] M_RESET    = 2'd1,
  parameter int         GATE_CYC   = 2,
  parameter int         HOLD_CYC   = 4,
  parameter int         LOCK_EDGES = 8,
  parameter int         TIMEOUT    = 255
) (
  input  logic       clk_ext,
  input  logic       rst,
  input  logic       cfg_req,
  input  logic [1:0] cfg_m,
  output logic       cfg_ack,
  output logic       cfg_nak,
  input  logic       div_clk4,
  output logic [1:0] div_m,
  output logic       div_rst_n,
  output logic       clk_en,
  output logic       busy,
  output logic       locked,
  output logic       err
);

  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int EW   = $clog2(LOCK_EDGES + 1);
  localparam int PMAX = (GATE_CYC > HOLD_CYC) ? GATE_CYC : HOLD_CYC;
  localparam int PW   = $clog2(PMAX + 1);

  localparam logic [PW-1:0] GATE_LAST = PW'(GATE_CYC - 1);
  localparam logic [PW-1:0] HOLD_LAST = PW'(HOLD_CYC - 1);
  localparam logic [EW-1:0] EDGE_FULL = EW'(LOCK_EDGES);
  localparam logic [TW-1:0] TIME_FULL = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_GATE,
    S_HOLD,
    S_LOCK,
    S_RUN,
    S_ERR
  } state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] phase_reg;
  logic [TW-1:0] timer_reg;
  logic [EW-1:0] edge_reg;
  logic          sync1_reg, sync2_reg, hist_reg;
  logic [1:0]    m_cap_reg;
  logic          req_used_reg;   // cfg_req not yet seen low since last ack/nak

  logic edge_pulse;
  logic idle;
  logic accept;
  logic nak_now;
  logic start_seq;
  logic lock_done;
  logic lock_timeout;

`ifdef DIV_MODE_CTRL_AUTO_RETRY_EN
  logic retry_reg;
  logic retry_take;
`endif

  assign edge_pulse   = sync2_reg & ~hist_reg;
  assign idle         = (state_reg == S_RUN) || (state_reg == S_ERR);
  assign accept       = idle && cfg_req && !req_used_reg;
  assign nak_now      = accept && (cfg_m == 2'd0);
  // Same M while running needs no sequence; ERR always restarts.
  assign start_seq    = accept && (cfg_m != 2'd0) &&
                        ((state_reg == S_ERR) || (cfg_m != div_m));
  assign lock_done    = (edge_reg == EDGE_FULL);
  assign lock_timeout = (timer_reg == TIME_FULL);

  always_comb begin
    state_next = state_reg;
    div_rst_n  = 1'b1;
    clk_en     = 1'b0;
    busy       = 1'b1;
    locked     = 1'b0;
    err        = 1'b0;
`ifdef DIV_MODE_CTRL_AUTO_RETRY_EN
    retry_take = 1'b0;
`endif
    case (state_reg)
      S_GATE: begin
        if (phase_reg == GATE_LAST) state_next = S_HOLD;
      end
      S_HOLD: begin
        div_rst_n = 1'b0;
        if (phase_reg == HOLD_LAST) state_next = S_LOCK;
      end
      S_LOCK: begin
        // Lock takes priority over a timeout landing on the same cycle.
        if (lock_done) begin
          state_next = S_RUN;
        end else if (lock_timeout) begin
`ifdef DIV_MODE_CTRL_AUTO_RETRY_EN
          if (!retry_reg) begin
            state_next = S_HOLD;
            retry_take = 1'b1;
          end else begin
            state_next = S_ERR;
          end
`else
          state_next = S_ERR;
`endif
        end
      end
      S_RUN: begin
        clk_en = 1'b1;
        locked = 1'b1;
        busy   = 1'b0;
        if (start_seq) state_next = S_GATE;
      end
      S_ERR: begin
        err       = 1'b1;
        div_rst_n = 1'b0;
        busy      = 1'b0;
        if (start_seq) state_next = S_GATE;
      end
      default: begin
        state_next = S_HOLD;
      end
    endcase
  end

  always_ff @(posedge clk_ext or posedge rst) begin
    if (rst) begin
      state_reg    <= S_HOLD;
      phase_reg    <= '0;
      timer_reg    <= '0;
      edge_reg     <= '0;
      sync1_reg    <= 1'b0;
      sync2_reg    <= 1'b0;
      hist_reg     <= 1'b0;
      div_m        <= M_RESET;
      m_cap_reg    <= M_RESET;
      cfg_ack      <= 1'b0;
      cfg_nak      <= 1'b0;
      req_used_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      sync1_reg <= div_clk4;
      sync2_reg <= sync1_reg;
      hist_reg  <= sync2_reg;

      // Phase counter restarts on every state change (including LOCK->HOLD).
      if (state_next != state_reg) begin
        phase_reg <= '0;
      end else if ((state_reg == S_GATE) || (state_reg == S_HOLD)) begin
        phase_reg <= phase_reg + PW'(1);
      end else begin
        phase_reg <= '0;
      end

      // Lock counters run only while staying in LOCK; both saturate.
      if ((state_reg == S_LOCK) && (state_next == S_LOCK)) begin
        if (timer_reg != TIME_FULL) timer_reg <= timer_reg + TW'(1);
        if (edge_pulse && (edge_reg != EDGE_FULL)) edge_reg <= edge_reg + EW'(1);
      end else begin
        timer_reg <= '0;
        edge_reg  <= '0;
      end

      if (start_seq) m_cap_reg <= cfg_m;
      if ((state_reg == S_GATE) && (state_next == S_HOLD)) div_m <= m_cap_reg;

      cfg_nak <= nak_now;
      if (!cfg_req) begin
        cfg_ack      <= 1'b0;
        req_used_reg <= 1'b0;
      end else if (accept) begin
        req_used_reg <= 1'b1;
        if (cfg_m != 2'd0) cfg_ack <= 1'b1;
      end
    end
  end

`ifdef DIV_MODE_CTRL_AUTO_RETRY_EN
  always_ff @(posedge clk_ext or posedge rst) begin
    if (rst) begin
      retry_reg <= 1'b0;
    end else if (retry_take) begin
      retry_reg <= 1'b1;
    end else if ((state_next == S_RUN) || (state_next == S_ERR)) begin
      retry_reg <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/div_mode_ctrl.md
Name: div_mode_ctrl

Overview:
- Sequencer for the FMDLL clock divider.
- Owns the divider's M select and its active-low reset.
- Gates the downstream use of the divided clocks.
- Performs glitch-safe reconfiguration: gate, hold divider in reset, apply M, release, verify lock by counting divided-clock edges, then re-enable.
- Runs entirely in the clk_ext domain.

Parameters:
- M_RESET, 2'd1: divider select applied out of reset.
- GATE_CYC, 2: cycles clk_en is low before the divider is reset.
- HOLD_CYC, 4: cycles div_rst_n is held low with the new M applied.
- LOCK_EDGES, 8: synchronized div_clk4 rising edges required to declare lock.
- TIMEOUT, 255: maximum LOCK-state cycles before declaring an error.

Ports:
- clk_ext, input, 1: reference clock; all logic on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- cfg_req, input, 1: 4-phase request for a new divider mode.
- cfg_m, input, 2: requested M; sampled on acceptance.
- cfg_ack, output, 1: request accepted; held until cfg_req falls.
- cfg_nak, output, 1: one-cycle pulse when a request is rejected (cfg_m == 0).
- div_clk4, input, 1: divider clk4 output, asynchronous to clk_ext.
- div_m, output, 2: divider M select.
- div_rst_n, output, 1: divider reset, active low.
- clk_en, output, 1: divided clocks valid for downstream use.
- busy, output, 1: a sequence is in progress.
- locked, output, 1: divider verified running at div_m.
- err, output, 1: lock timeout; sticky until the next accepted request.

Behaviour:
- Reset values (rst=1, asynchronous):
  - state = HOLD, div_m = M_RESET, div_rst_n = 0, clk_en = 0.
  - busy = 1, locked = 0, err = 0, cfg_ack = 0, cfg_nak = 0.
  - All counters and synchronizer flops = 0.
- Bring-up: after rst falls, the power-up sequence starts in HOLD without any request.
- States:
  - GATE: clk_en = 0, busy = 1, locked = 0. Lasts GATE_CYC cycles, then goes to HOLD.
  - HOLD: div_rst_n = 0. div_m takes the captured M on the HOLD entry cycle. Lasts HOLD_CYC cycles, then goes to LOCK.
  - LOCK: div_rst_n = 1. Edge counter and cycle timer both start at 0.
    - Edge counter reaches LOCK_EDGES: go to RUN.
    - Timer reaches TIMEOUT: go to ERR.
    - Both on the same cycle: RUN wins.
  - RUN: clk_en = 1, locked = 1, busy = 0. Entered the cycle after the final edge is counted.
  - ERR: err = 1, div_rst_n = 0, clk_en = 0, locked = 0, busy = 0.
- Edge detect:
  - div_clk4 passes through a 2-flop synchronizer plus a history flop.
  - An edge is counted when sync2 & ~hist.
  - Edges are counted only in LOCK.
- Handshake:
  - A request is accepted only in RUN or ERR, when cfg_req = 1 and the previous accepted request has completed its 4-phase cycle (cfg_req seen low since the last ack).
  - cfg_ack rises the cycle after acceptance and falls the cycle after cfg_req is sampled low.
  - cfg_req while busy is neither acked nor lost; it is accepted once RUN or ERR is reached.
- Request outcomes:
  - cfg_m == 0: no ack; cfg_nak pulses for one cycle; state, div_m, locked and err are unchanged. cfg_nak fires only once per req assertion.
  - cfg_m == div_m in RUN: ack only, no sequence, clk_en stays 1.
  - Any other valid cfg_m, or any valid request in ERR: capture cfg_m, clear err, go to GATE.
- Widths:
  - Timer is $clog2(TIMEOUT+1) bits; edge counter is $clog2(LOCK_EDGES+1) bits.
  - Both saturate and never wrap.
- rst mid-sequence: immediate return to reset values; the power-up sequence restarts with M_RESET and any captured M is discarded.

Optional Feature:
- Macro: DIV_MODE_CTRL_AUTO_RETRY_EN.
- Defined:
  - The first LOCK timeout of a sequence re-enters HOLD (same M) instead of ERR.
  - Counters are cleared on re-entry.
  - A second timeout goes to ERR.
  - The retry flag clears on entry to RUN, on entry to ERR, or on rst.
- Undefined: the first timeout goes directly to ERR.

Test Plan:
- Power-up, div_clk4 toggling every 4 clk_ext cycles → div_rst_n rises after 4 cycles; locked = 1, clk_en = 1, div_m = 1 after 8 edges.
- In RUN, cfg_req with cfg_m = 3 → ack next cycle; clk_en low for 2 cycles; div_m = 3 and div_rst_n = 0 for 4 cycles; locked after 8 edges; ack drops after req drops.
- cfg_m = 0 in RUN → single cfg_nak pulse, no ack, div_m and locked unchanged; cfg_m equal to current div_m → ack with clk_en held at 1 throughout.
- div_clk4 stuck low in LOCK → err = 1 at timer = 255, div_rst_n = 0; with DIV_MODE_CTRL_AUTO_RETRY_EN defined, one extra HOLD/LOCK pass first. A new valid request then clears err.
- cfg_req during GATE/HOLD/LOCK → no ack until RUN, then accepted; rst asserted in LOCK → all outputs return to reset values immediately.
